game_phase_seq: RTL

GAME_PHASE_SEQ -- requirements
Module: game_phase_seq

---
 rtl/game_phase_if.sv | 22 ++
 rtl/game_phase_seq.sv | 84 ++++++++
 2 files changed

// File: rtl/game_phase_if.sv
// game_phase_if: player/countdown inputs and phase, level, spawn and display outputs of the sequencer.
interface game_phase_if;
    logic       start_game;
    logic       pause;
    logic [5:0] time_left;
    logic       run_timer;
    logic [2:0] state;
    logic [1:0] level;
    logic       spawn_tick;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       warn_led;
    logic       game_over;
    modport master (
        output start_game, pause, time_left,
        input  run_timer, state, level, spawn_tick, tens, ones, warn_led, game_over
    );
    modport slave (
        input  start_game, pause, time_left,
        output run_timer, state, level, spawn_tick, tens, ones, warn_led, game_over
    );
endinterface

// File: rtl/game_phase_seq.sv
// game_phase_seq: whack-a-mole phase sequencer (idle/ready/play/warn/over) with difficulty level and spawn strobe.
module game_phase_seq #(
    parameter int READY_SECS = 3,
    parameter int WARN_SECS  = 10,
    parameter int LEVEL_STEP = 15
) (
    input logic         clk_1Hz,
    input logic         reset,
    game_phase_if.slave gp
);
    localparam logic [2:0] IDLE = 3'd0, READY = 3'd1, PLAY = 3'd2, WARN = 3'd3, OVER = 3'd4;
    logic [2:0] state_q, state_d, ready_cnt_q, ready_cnt_d, spawn_cnt_q, spawn_cnt_d;
    logic [1:0] level_q, level_d, lvl_calc;
    logic       spawn_tick_q, spawn_tick_d, active;
    logic [5:0] tl, elapsed, quot, disp;
    assign tl       = gp.time_left > 6'd60 ? 6'd60 : gp.time_left;
    assign elapsed  = 6'd60 - tl;
    assign quot     = elapsed / 6'(LEVEL_STEP);
    assign lvl_calc = quot > 6'd3 ? 2'd3 : quot[1:0];
    assign active   = state_q == PLAY || state_q == WARN;
    always_comb begin
        state_d      = state_q;
        ready_cnt_d  = ready_cnt_q;
        spawn_cnt_d  = spawn_cnt_q;
        level_d      = level_q;
        spawn_tick_d = 1'b0;
        case (state_q)
            IDLE: begin
                level_d     = 2'd0;
                spawn_cnt_d = 3'd0;
                if (gp.start_game) begin
                    state_d     = READY;
                    ready_cnt_d = 3'(READY_SECS);
                end
            end
            READY: begin
                level_d     = 2'd0;
                ready_cnt_d = ready_cnt_q - 3'd1;
                if (!gp.start_game) state_d = IDLE;
                else if (ready_cnt_q == 3'd1) begin
                    state_d     = PLAY;
                    spawn_cnt_d = 3'd4;
                end
            end
            PLAY, WARN: begin
                if (!gp.start_game) state_d = IDLE;
                else if (!gp.pause) begin
                    level_d      = lvl_calc;
                    state_d      = tl == 6'd0 ? OVER :
                                   (state_q == PLAY && tl <= 6'(WARN_SECS)) ? WARN : state_q;
                    // a strobe that would land in OVER is dropped so OVER never shows a tick
                    spawn_tick_d = spawn_cnt_q == 3'd1 && tl != 6'd0;
                    spawn_cnt_d  = spawn_cnt_q == 3'd1 ? 3'd4 - {1'b0, level_q} : spawn_cnt_q - 3'd1;
                end
            end
            OVER: state_d = gp.start_game ? OVER : IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_1Hz or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ready_cnt_q  <= 3'd0;
            spawn_cnt_q  <= 3'd0;
            level_q      <= 2'd0;
            spawn_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_cnt_q  <= ready_cnt_d;
            spawn_cnt_q  <= spawn_cnt_d;
            level_q      <= level_d;
            spawn_tick_q <= spawn_tick_d;
        end
    end
    assign disp          = state_q == READY ? {3'd0, ready_cnt_q} : active ? tl : state_q == OVER ? 6'd0 : 6'd60;
    assign gp.tens       = 4'(disp / 6'd10);
    assign gp.ones       = 4'(disp % 6'd10);
    assign gp.run_timer  = active && !gp.pause;
    assign gp.state      = state_q;
    assign gp.level      = level_q;
    assign gp.spawn_tick = spawn_tick_q;
    assign gp.warn_led   = state_q == WARN;
    assign gp.game_over  = state_q == OVER;
endmodule
